// File: rtl/alu_issue.sv
// alu_issue: RV32I decode-to-ALU issue register with a valid/ready handshake.
// Decodes the presented instruction into ALU operands/op and holds it until execute consumes it.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_func,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_load,
    output logic        is_store,
    output logic        illegal
);
    typedef enum logic [3:0] {
        FN_ADD    = 4'b0000, FN_SUB    = 4'b0001, FN_SLL  = 4'b0010, FN_SRL = 4'b0011,
        FN_SLTU   = 4'b0100, FN_AND    = 4'b0101, FN_OR   = 4'b0110, FN_XOR = 4'b0111,
        FN_SRA    = 4'b1000, FN_SLT    = 4'b1001, FN_PASS_A = 4'b1010, FN_PASS_B = 4'b1011,
        FN_EQ     = 4'b1100, FN_NE     = 4'b1101, FN_SGE  = 4'b1110, FN_GEU = 4'b1111
    } alu_func_e;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011, OPC_OP_IMM = 7'b0010011, OPC_LOAD  = 7'b0000011,
        OPC_STORE  = 7'b0100011, OPC_LUI    = 7'b0110111, OPC_AUIPC = 7'b0010111,
        OPC_JAL    = 7'b1101111, OPC_JALR   = 7'b1100111, OPC_BRANCH = 7'b1100011
    } opcode_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_func_e   func;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic        jmp;
        logic        ld;
        logic        st;
        logic        ill;
    } issue_t;

    issue_t      dec;
    issue_t      issue_d, issue_q;
    logic        out_valid_d, out_valid_q;
    logic        writes_rd;
    logic        accept;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_u;

    // alt selects sra for funct3=101; sub only when the register form allows it
    function automatic alu_func_e arith_func(input logic [2:0] f3, input logic alt, input logic allow_sub);
        case (f3)
            3'b000:  arith_func = (alt && allow_sub) ? FN_SUB : FN_ADD;
            3'b001:  arith_func = FN_SLL;
            3'b010:  arith_func = FN_SLT;
            3'b011:  arith_func = FN_SLTU;
            3'b100:  arith_func = FN_XOR;
            3'b101:  arith_func = alt ? FN_SRA : FN_SRL;
            3'b110:  arith_func = FN_OR;
            default: arith_func = FN_AND;
        endcase
    endfunction

    assign funct3 = instr[14:12];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    always_comb begin
        dec       = '0;
        dec.rd    = instr[11:7];
        writes_rd = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                dec.a     = rs1_data;
                dec.b     = rs2_data;
                dec.func  = arith_func(funct3, instr[30], 1'b1);
                writes_rd = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.a     = rs1_data;
                dec.b     = imm_i;
                dec.func  = arith_func(funct3, instr[30], 1'b0);
                writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                dec.a     = rs1_data;
                dec.b     = imm_i;
                dec.ld    = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                dec.a  = rs1_data;
                dec.b  = imm_s;
                dec.st = 1'b1;
            end
            OPC_LUI: begin
                dec.func  = FN_PASS_B;
                dec.b     = imm_u;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a     = pc;
                dec.b     = imm_u;
                writes_rd = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec.a     = pc;
                dec.b     = 32'd4;
                dec.jmp   = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                dec.a  = rs1_data;
                dec.b  = rs2_data;
                dec.br = 1'b1;
                case (funct3)
                    3'b000:  dec.func = FN_EQ;
                    3'b001:  dec.func = FN_NE;
                    3'b100:  dec.func = FN_SLT;
                    3'b101:  dec.func = FN_SGE;
                    3'b110:  dec.func = FN_SLTU;
                    3'b111:  dec.func = FN_GEU;
                    default: begin
                        dec.a   = '0;
                        dec.b   = '0;
                        dec.br  = 1'b0;
                        dec.ill = 1'b1;
                    end
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
        dec.we = writes_rd && (instr[11:7] != 5'd0);
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // flush only clears valid; data registers change solely on accept or reset
    always_comb begin
        out_valid_d = out_valid_q;
        issue_d     = issue_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            issue_d     = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            issue_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            issue_q     <= issue_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_a     = issue_q.a;
    assign alu_b     = issue_q.b;
    assign alu_func  = issue_q.func;
    assign rd        = issue_q.rd;
    assign reg_we    = issue_q.we;
    assign is_branch = issue_q.br;
    assign is_jump   = issue_q.jmp;
    assign is_load   = issue_q.ld;
    assign is_store  = issue_q.st;
    assign illegal   = issue_q.ill;
endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed and randomized instruction stream with a queue
// scoreboard fed by a table-driven decode model and a negedge monitor.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_ready, out_valid;
    logic [31:0] instr, pc, rs1_data, rs2_data, alu_a, alu_b;
    logic [3:0]  alu_func;
    logic [4:0]  rd;
    logic        reg_we, is_branch, is_jump, is_load, is_store, illegal;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic        jmp;
        logic        ld;
        logic        st;
        logic        ill;
    } exp_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    exp_t exp_q[$];
    exp_t last = '0;
    bit   mvalid = 1'b0;

    logic [3:0] arith_map [8] = '{4'h0, 4'h2, 4'h9, 4'h4, 4'h7, 4'h3, 4'h6, 4'h5};
    logic [3:0] br_map    [8] = '{4'hC, 4'hD, 4'h0, 4'h0, 4'h9, 4'hE, 4'h4, 4'hF};
    bit         br_ok     [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [6:0] legal_ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h63};

    alu_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .rd(rd), .reg_we(reg_we),
        .is_branch(is_branch), .is_jump(is_jump), .is_load(is_load),
        .is_store(is_store), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        logic [2:0] f3;
        bit         wr;
        e  = '0;
        f3 = ins[14:12];
        wr = 1'b0;
        e.rd = ins[11:7];
        case (ins[6:0])
            7'h33: begin
                e.a = r1; e.b = r2; e.func = arith_map[f3]; wr = 1'b1;
                if (ins[30] && f3 == 3'd0) e.func = 4'h1;
                if (ins[30] && f3 == 3'd5) e.func = 4'h8;
            end
            7'h13: begin
                e.a = r1; e.b = {{20{ins[31]}}, ins[31:20]}; e.func = arith_map[f3]; wr = 1'b1;
                if (ins[30] && f3 == 3'd5) e.func = 4'h8;
            end
            7'h03: begin e.a = r1; e.b = {{20{ins[31]}}, ins[31:20]}; e.ld = 1'b1; wr = 1'b1; end
            7'h23: begin e.a = r1; e.b = {{20{ins[31]}}, ins[31:25], ins[11:7]}; e.st = 1'b1; end
            7'h37: begin e.func = 4'hB; e.b = {ins[31:12], 12'h000}; wr = 1'b1; end
            7'h17: begin e.a = pcv; e.b = {ins[31:12], 12'h000}; wr = 1'b1; end
            7'h6F, 7'h67: begin e.a = pcv; e.b = 32'd4; e.jmp = 1'b1; wr = 1'b1; end
            7'h63: begin
                if (br_ok[f3]) begin
                    e.a = r1; e.b = r2; e.func = br_map[f3]; e.br = 1'b1;
                end else begin
                    e.ill = 1'b1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.we = wr && (ins[11:7] != 5'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [78:0] act, input logic [78:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: tracks occupancy of the issue register and the queue of expected entries
    always @(posedge clk or posedge rst) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            mvalid = 1'b0;
            last   = '0;
        end else if (flush) begin
            exp_q.delete();
            mvalid = 1'b0;
        end else if (in_valid && (!mvalid || out_ready)) begin
            if (mvalid && exp_q.size() > 0) void'(exp_q.pop_front());
            e = ref_decode(instr, pc, rs1_data, rs2_data);
            exp_q.push_back(e);
            last   = e;
            mvalid = 1'b1;
        end else if (mvalid && out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            mvalid = 1'b0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t got;
        exp_t want;
        got  = {alu_a, alu_b, alu_func, rd, reg_we, is_branch, is_jump, is_load, is_store, illegal};
        want = (mvalid && exp_q.size() > 0) ? exp_q[0] : last;
        check("out_valid", 79'(out_valid), 79'(mvalid));
        check("in_ready", 79'(in_ready), 79'(!mvalid || out_ready));
        check("outputs", got, want);
    end

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic ordy, input logic fl);
        in_valid  = v;
        instr     = i;
        pc        = p;
        rs1_data  = r1;
        rs2_data  = r2;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        drive(1, 32'h002081B3, 32'h0,   32'd5, 32'd7, 1, 0);   // add x3,x1,x2
        drive(1, 32'h40315093, 32'h4,   32'hF000_0000, 32'd1, 1, 0); // srai x1,x2,3
        drive(1, 32'hFFF00013, 32'h8,   32'd9, 32'd9, 1, 0);   // addi x0,x0,-1
        drive(1, 32'h0020E063, 32'h100, 32'd1, 32'd2, 1, 0);   // bltu x1,x2
        drive(1, 32'h000000EF, 32'h100, 32'd0, 32'd0, 1, 0);   // jal x1
        drive(1, 32'h0000007F, 32'h104, 32'd3, 32'd4, 1, 0);   // illegal opcode
        drive(1, 32'h0020A033, 32'h108, 32'h8000_0000, 32'd1, 1, 0); // slt funct3 010 for branch-only-illegal contrast
        drive(1, 32'h0020A063, 32'h10C, 32'd1, 32'd2, 1, 0);   // branch funct3 010: illegal
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

        // stall three cycles with a new instruction waiting, then release
        drive(1, 32'h00B50533, 32'h200, 32'd11, 32'd22, 1, 0);
        repeat (3) drive(1, 32'h00C58633, 32'h204, 32'd33, 32'd44, 0, 0);
        drive(1, 32'h00D686B3, 32'h208, 32'd55, 32'd66, 1, 0);
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

        // flush with a held instruction and another presented
        drive(1, 32'h00B50533, 32'h300, 32'd1, 32'd2, 0, 0);
        drive(1, 32'h00C58633, 32'h304, 32'd3, 32'd4, 0, 1);
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

        // reset asserted mid-stall
        drive(1, 32'h123450B7, 32'h400, 32'd1, 32'd2, 0, 0);
        drive(1, 32'h00C58633, 32'h404, 32'd3, 32'd4, 0, 0);
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 79'(out_valid), 79'(0));
        check("rst_outputs", {alu_a, alu_b, alu_func, rd, reg_we, is_branch, is_jump,
                              is_load, is_store, illegal}, 79'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 32'h00000297, 32'h500, 32'd0, 32'd0, 1, 0);   // auipc x5,0 right after reset

        for (int i = 0; i < 600; i++) begin
            r  = $urandom();
            op = ($urandom_range(0, 11) < 10) ? legal_ops[$urandom_range(0, 9)] : 7'($urandom());
            drive($urandom_range(0, 3) != 0, {r[31:7], op}, $urandom(), $urandom(), $urandom(),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
